// File: rtl/pix_count_ctrl_if.sv
// Avalon-MM register bus for pix_count_ctrl. The host (CPU bridge or bench)
// drives the request side, and the block returns registered read data.
interface pix_count_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pix_count_ctrl.sv
// Per-frame thresholded pixel counter with an Avalon-MM control/status block.
// Frames are delimited by sof/eof beats, and the last frame count is latched into COUNT and n_pix_out.
module pix_count_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  pix_count_ctrl_if.slave     avs,
  input  logic                pix_valid,
  input  logic                pix_sof,
  input  logic                pix_eof,
  input  logic                pix_hit,
  output logic [31:0]         n_pix_out,
  output logic                irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_COUNT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_last;
  logic [31:0]      r_frames;
  logic [31:0]      r_readdata;
  logic             r_cont;
  logic             r_irq_en;
  logic             r_done;
  logic             r_overrun;
  logic             r_sat;

  logic             w_wr;
  logic             w_ctrl_wr;
  logic             w_stat_wr;
  logic             w_start;
  logic             w_abort;
  logic [3:0]       w_clr;
  logic             w_sof;
  logic             w_eof;
  logic             w_hit;
  logic [CNT_W-1:0] w_cnt_hit;
  logic [CNT_W-1:0] w_frame_val;
  logic             w_frame_end;
  logic             w_early_sof;
  logic             w_set_sat;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wd;

  always_comb begin
    w_wr        = avs.chipselect & ~avs.write_n;
    w_ctrl_wr   = w_wr & (avs.address == 2'd0);
    w_stat_wr   = w_wr & (avs.address == 2'd1);
    w_start     = w_ctrl_wr & avs.writedata[0];
    w_abort     = w_ctrl_wr & avs.writedata[3];
    w_clr       = {4{w_stat_wr}} & avs.writedata[3:0];
    w_unused_wd = ^avs.writedata[31:4];

    w_sof = pix_valid & pix_sof;
    w_eof = pix_valid & pix_eof;
    w_hit = pix_valid & pix_hit;

    // Saturating increment: a hit at full scale leaves the counter unchanged.
    w_cnt_hit = (w_hit && (r_cnt != CNT_MAX)) ? r_cnt + CNT_W'(1) : r_cnt;

    // Abort overrides any pixel activity in the same cycle.
    w_frame_end = ~w_abort & w_eof &
                  ((r_state == S_COUNT) | ((r_state == S_ARMED) & w_sof));
    w_frame_val = (r_state == S_ARMED) ? CNT_W'(w_hit) : w_cnt_hit;
    w_early_sof = ~w_abort & (r_state == S_COUNT) & w_sof & ~w_eof;
    w_set_sat   = ~w_abort & (r_state == S_COUNT) & w_hit & (r_cnt == CNT_MAX) &
                  ~(w_sof & ~w_eof);

    case (avs.address)
      2'd0:    w_rd_mux = {29'd0, r_irq_en, r_cont, 1'b0};
      2'd1:    w_rd_mux = {28'd0, r_sat, r_overrun, r_done, r_state != S_IDLE};
      2'd2:    w_rd_mux = 32'(r_last);
      default: w_rd_mux = r_frames;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_last     <= '0;
      r_frames   <= '0;
      r_readdata <= '0;
      r_cont     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      r_readdata <= w_rd_mux;

      // Hardware set terms are OR-ed after the W1C mask so a same-cycle set wins.
      r_done    <= (r_done & ~w_clr[1]) | w_frame_end;
      r_overrun <= (r_overrun & ~w_clr[2]) | w_early_sof | (w_frame_end & r_done);
      r_sat     <= (r_sat & ~w_clr[3]) | w_set_sat;

      if (w_ctrl_wr) begin
        r_cont   <= avs.writedata[1];
        r_irq_en <= avs.writedata[2];
      end

      if (w_frame_end) begin
        r_last   <= w_frame_val;
        r_frames <= r_frames + 32'd1;
      end

      if (w_abort) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) r_state <= S_ARMED;
          end
          S_ARMED: begin
            if (w_sof) begin
              r_cnt   <= CNT_W'(w_hit);
              r_state <= w_eof ? (r_cont ? S_ARMED : S_IDLE) : S_COUNT;
            end
          end
          S_COUNT: begin
            if (w_eof) begin
              r_cnt   <= '0;
              r_state <= r_cont ? S_ARMED : S_IDLE;
            end else if (w_sof) begin
              r_cnt <= CNT_W'(w_hit);
            end else begin
              r_cnt <= w_cnt_hit;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign avs.readdata = r_readdata;
  assign n_pix_out    = 32'(r_last);
  assign irq          = r_irq_en & (r_done | r_overrun);

endmodule

// File: tb/tb_pix_count_ctrl.sv
// Bench for pix_count_ctrl (CNT_W=4): a directed vector table, hand-written corner sequences,
// then random traffic, all checked cycle by cycle against a frame-level reference model.
module tb_pix_count_ctrl;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  localparam int P_IDLE  = 0;
  localparam int P_ARMED = 1;
  localparam int P_COUNT = 2;

  logic        clk;
  logic        reset_n;
  logic        pix_valid, pix_sof, pix_eof, pix_hit;
  logic [31:0] n_pix_out;
  logic        irq;

  pix_count_ctrl_if bus ();

  pix_count_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .avs       (bus),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_eof   (pix_eof),
    .pix_hit   (pix_hit),
    .n_pix_out (n_pix_out),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame phase plus an unbounded hit tally, clamped only when latched.
  int          m_phase;
  int          m_hits;
  int          m_last;
  logic [31:0] m_frames;
  logic        m_cont, m_ien, m_done, m_ovr, m_sat;

  typedef struct {
    logic [1:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic        v, s, e, h;
    logic [31:0] rd;
    logic [31:0] npix;
    logic        irq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] addr, input logic cs, input logic wn,
                              input logic [31:0] wd, input logic v, input logic s,
                              input logic e, input logic h, input logic [31:0] rd,
                              input logic [31:0] npix, input logic ir);
    vec_t r;
    r.addr = addr; r.cs = cs; r.wn = wn; r.wd = wd;
    r.v = v; r.s = s; r.e = e; r.h = h;
    r.rd = rd; r.npix = npix; r.irq = ir;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_view(input logic [1:0] a);
    case (a)
      2'd0:    return {29'd0, m_ien, m_cont, 1'b0};
      2'd1:    return {28'd0, m_sat, m_ovr, m_done, (m_phase != P_IDLE)};
      2'd2:    return 32'(m_last);
      default: return m_frames;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_hits = 0; m_last = 0; m_frames = '0;
    m_cont = 0; m_ien = 0; m_done = 0; m_ovr = 0; m_sat = 0;
  endtask

  // One clock: drive inputs, advance the model, then compare all outputs 1 ns after the edge.
  task automatic step(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd,
                      input logic v, input logic s, input logic e, input logic h);
    logic [31:0] exp_rd;
    logic wr, cw, sw, ab, st, fin, early, satset;
    bus.address = a; bus.chipselect = cs; bus.write_n = wn; bus.writedata = wd;
    pix_valid = v; pix_sof = s; pix_eof = e; pix_hit = h;

    exp_rd = reg_view(a);
    wr = cs & ~wn;
    cw = wr && (a == 2'd0);
    sw = wr && (a == 2'd1);
    ab = cw & wd[3];
    st = cw & wd[0];
    fin = 0; early = 0; satset = 0;
    if (ab) begin
      m_phase = P_IDLE;
      m_hits  = 0;
    end else begin
      case (m_phase)
        P_IDLE:  if (st) m_phase = P_ARMED;
        P_ARMED: if (v && s) begin
          m_hits = int'(h);
          if (e) fin = 1; else m_phase = P_COUNT;
        end
        default: if (v) begin
          if (s && !e) begin
            early  = 1;
            m_hits = int'(h);
          end else begin
            m_hits += int'(h);
            if (h && m_hits > MAXC) satset = 1;
            if (e) fin = 1;
          end
        end
      endcase
    end
    if (fin) begin
      m_last   = (m_hits > MAXC) ? MAXC : m_hits;
      m_frames = m_frames + 1;
      m_phase  = m_cont ? P_ARMED : P_IDLE;
    end
    m_ovr  = (m_ovr && !(sw && wd[2])) || early || (fin && m_done);
    m_done = (m_done && !(sw && wd[1])) || fin;
    m_sat  = (m_sat && !(sw && wd[3])) || satset;
    if (cw) begin
      m_cont = wd[1];
      m_ien  = wd[2];
    end

    @(posedge clk);
    #1;
    chk("rd", bus.readdata, exp_rd);
    chk("npix", n_pix_out, 32'(m_last));
    chk("irq", {31'd0, irq}, {31'd0, m_ien & (m_done | m_ovr)});
  endtask

  task automatic idle();
    step(2'd0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    step(a, 1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic beat(input logic s, input logic e, input logic h);
    step(2'd0, 1'b0, 1'b1, 32'd0, 1'b1, s, e, h);
  endtask

  task automatic rd_expect(input logic [1:0] a, input logic [31:0] exp, input string name);
    step(a, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk(name, bus.readdata, exp);
  endtask

  task automatic frame(input int n, input int nh);
    for (int i = 0; i < n; i++) beat(i == 0, i == n - 1, i < nh);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next clock.
  task automatic do_reset();
    bus.chipselect = 0; bus.write_n = 1; bus.address = 0; bus.writedata = 0;
    pix_valid = 0; pix_sof = 0; pix_eof = 0; pix_hit = 0;
    reset_n = 1'b0;
    #2;
    chk("rst_rd", bus.readdata, 32'd0);
    chk("rst_npix", n_pix_out, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    reset_n = 1'b0;
    bus.address = 0; bus.chipselect = 0; bus.write_n = 1; bus.writedata = 0;
    pix_valid = 0; pix_sof = 0; pix_eof = 0; pix_hit = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("por_rd", bus.readdata, 32'd0);
    chk("por_npix", n_pix_out, 32'd0);
    chk("por_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;

    // Basic 10-beat frame, single-beat unread frame, irq and W1C, clear race.
    //            addr cs wn wd   v s e h  rd npix irq
    tbl.push_back(mk(0, 0, 1, 0,   0,0,0,0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1,   0,0,0,0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,   1,1,0,1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,   1,0,0,0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,   0,0,1,1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,   1,0,0,0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,   1,0,0,1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,   1,0,0,0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,   1,0,0,1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,   1,0,0,0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,   1,0,0,0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,   1,0,0,0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,   1,0,1,1, 1, 4, 0));
    tbl.push_back(mk(2, 0, 1, 0,   0,0,0,0, 4, 4, 0));
    tbl.push_back(mk(1, 0, 1, 0,   0,0,0,0, 2, 4, 0));
    tbl.push_back(mk(3, 0, 1, 0,   0,0,0,0, 1, 4, 0));
    tbl.push_back(mk(0, 1, 0, 5,   0,0,0,0, 0, 4, 1));
    tbl.push_back(mk(1, 0, 1, 0,   1,1,1,1, 3, 1, 1));
    tbl.push_back(mk(1, 0, 1, 0,   0,0,0,0, 6, 1, 1));
    tbl.push_back(mk(1, 1, 0, 6,   0,0,0,0, 6, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0,   0,0,0,0, 0, 1, 0));
    tbl.push_back(mk(2, 0, 1, 0,   0,0,0,0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 5,   0,0,0,0, 4, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0,   1,1,0,0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 0, 2,   1,0,1,1, 1, 1, 1));
    tbl.push_back(mk(1, 0, 1, 0,   0,0,0,0, 2, 1, 1));
    tbl.push_back(mk(3, 0, 1, 0,   0,0,0,0, 3, 1, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].addr, tbl[i].cs, tbl[i].wn, tbl[i].wd,
           tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].h);
      chk($sformatf("tbl%0d_rd", i), bus.readdata, tbl[i].rd);
      chk($sformatf("tbl%0d_npix", i), n_pix_out, tbl[i].npix);
      chk($sformatf("tbl%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].irq});
    end

    // Continuous mode: three frames, done cleared between them, then cont dropped mid-frame.
    do_reset();
    wr_reg(2'd0, 32'h3);
    frame(5, 3);
    wr_reg(2'd1, 32'h2);
    frame(4, 0);
    wr_reg(2'd1, 32'h2);
    frame(9, 7);
    rd_expect(2'd1, 32'h3, "cont_status");
    rd_expect(2'd2, 32'd7, "cont_count");
    rd_expect(2'd3, 32'd3, "cont_frames");
    wr_reg(2'd1, 32'h2);
    beat(1'b1, 1'b0, 1'b1);
    wr_reg(2'd0, 32'h0);
    beat(1'b0, 1'b1, 1'b1);
    rd_expect(2'd1, 32'h2, "cont_off_status");
    rd_expect(2'd2, 32'd2, "cont_off_count");

    // Early sof restarts the count and flags overrun without latching.
    do_reset();
    wr_reg(2'd0, 32'h1);
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b0, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b0);
    rd_expect(2'd2, 32'd0, "early_nolatch");
    beat(1'b0, 1'b0, 1'b1);
    beat(1'b0, 1'b0, 1'b1);
    beat(1'b0, 1'b1, 1'b0);
    rd_expect(2'd1, 32'h6, "early_status");
    rd_expect(2'd2, 32'd2, "early_count");

    // Saturation at 2^CNT_W-1, then abort (with start) mid-frame.
    do_reset();
    wr_reg(2'd0, 32'h1);
    frame(20, 20);
    rd_expect(2'd2, 32'd15, "sat_count");
    rd_expect(2'd1, 32'hA, "sat_status");
    chk("sat_npix", n_pix_out, 32'd15);
    wr_reg(2'd0, 32'h1);
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b0, 1'b0, 1'b1);
    wr_reg(2'd0, 32'h9);
    rd_expect(2'd1, 32'hA, "abort_status");
    beat(1'b0, 1'b1, 1'b1);
    beat(1'b1, 1'b1, 1'b1);
    rd_expect(2'd2, 32'd15, "abort_count");
    rd_expect(2'd3, 32'd1, "abort_frames");

    // Reset mid-frame: outputs clear, and eof/sof beats are ignored until a new start.
    wr_reg(2'd0, 32'h1);
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b0, 1'b0, 1'b1);
    rd_expect(2'd2, 32'd15, "prerst_count");
    do_reset();
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b0, 1'b1, 1'b1);
    beat(1'b1, 1'b1, 1'b1);
    rd_expect(2'd2, 32'd0, "postrst_count");
    rd_expect(2'd3, 32'd0, "postrst_frames");
    rd_expect(2'd1, 32'd0, "postrst_status");

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      logic [1:0]  a;
      logic        cs, wn;
      logic [31:0] wd;
      a  = 2'($urandom_range(0, 3));
      cs = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 3) != 0);
      wd = $urandom;
      if (a == 2'd0) wd[3] = ($urandom_range(0, 15) == 0);
      step(a, cs, wn, wd,
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1));
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
